// File: rtl/cenn_mac_ctrl_if.sv
// Bundle between the cell-update logic, the shared multiplier and cenn_mac_ctrl.
// slave is the sequencer's view; master is the surrounding logic's view.
interface cenn_mac_ctrl_if #(
    parameter int WIDTH = 15,
    parameter int TAPS  = 9
) ();
    logic                    start;
    logic                    clear;
    logic [TAPS*WIDTH-1:0]   coef_flat;
    logic [TAPS*WIDTH-1:0]   data_flat;
    logic [WIDTH-1:0]        bias;
    logic [WIDTH-1:0]        mul_a;
    logic [WIDTH-1:0]        mul_b;
    logic [WIDTH-1:0]        mul_p;
    logic                    busy;
    logic                    done;
    logic [WIDTH-1:0]        result;
    logic                    sat;

    modport slave (
        input  start, clear, coef_flat, data_flat, bias, mul_p,
        output mul_a, mul_b, busy, done, result, sat
    );

    modport master (
        output start, clear, coef_flat, data_flat, bias, mul_p,
        input  mul_a, mul_b, busy, done, result, sat
    );
endinterface

// File: rtl/cenn_mac_ctrl.sv
// CeNN template-sum sequencer: bias + sum(coef[k]*data[k]) through one shared
// registered multiplier, one tap per cycle, saturated to WIDTH bits.
module cenn_mac_ctrl #(
    parameter int WIDTH = 15,
    parameter int FRAC  = 9,
    parameter int TAPS  = 9,
    parameter int AW    = WIDTH + 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cenn_mac_ctrl_if.slave  bus
);
    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IW-1:0]        LAST = IW'(TAPS - 1);
    localparam logic signed [AW-1:0] MAXV = AW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = AW'(-(2 ** (WIDTH - 1)));
    localparam logic [WIDTH-1:0]     POS_CLIP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     NEG_CLIP = {1'b1, {(WIDTH-1){1'b0}}};

    if (AW < WIDTH + $clog2(TAPS + 1) || FRAC >= WIDTH) begin : g_bad_cfg
        $error("cenn_mac_ctrl: accumulator too narrow or FRAC >= WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic signed [AW-1:0]        acc_q, acc_d, acc_sum;
    logic                        acc_en_q, acc_en_d;
    logic [TAPS-1:0][WIDTH-1:0]  coef_q, coef_d, data_q, data_d;
    logic [WIDTH-1:0]            result_q, result_d;
    logic                        sat_q, sat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start) state_d = S_ISSUE;
                S_ISSUE: if (idx_q == LAST) state_d = S_DRAIN;
                S_DRAIN: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Products return one cycle after issue, so the add enable trails ISSUE by one.
    always_comb begin
        idx_d    = idx_q;
        coef_d   = coef_q;
        data_d   = data_q;
        result_d = result_q;
        sat_d    = sat_q;
        acc_en_d = (state_q == S_ISSUE) && !bus.clear;
        acc_sum  = acc_q + (acc_en_q ? $signed({{(AW-WIDTH){bus.mul_p[WIDTH-1]}}, bus.mul_p})
                                     : $signed({AW{1'b0}}));
        acc_d    = acc_sum;
        if (bus.clear) begin
            idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    coef_d = bus.coef_flat;
                    data_d = bus.data_flat;
                    acc_d  = $signed({{(AW-WIDTH){bus.bias[WIDTH-1]}}, bus.bias});
                    idx_d  = '0;
                end
                S_ISSUE: idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
                S_DRAIN: begin
                    if (acc_sum > MAXV) begin
                        result_d = POS_CLIP;
                        sat_d    = 1'b1;
                    end else if (acc_sum < MINV) begin
                        result_d = NEG_CLIP;
                        sat_d    = 1'b1;
                    end else begin
                        result_d = acc_sum[WIDTH-1:0];
                        sat_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            acc_q    <= '0;
            acc_en_q <= 1'b0;
            coef_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            acc_en_q <= acc_en_d;
            coef_q   <= coef_d;
            data_q   <= data_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

    always_comb begin
        bus.mul_a  = '0;
        bus.mul_b  = '0;
        bus.busy   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        bus.done   = (state_q == S_DONE);
        bus.result = result_q;
        bus.sat    = sat_q;
        if (state_q == S_ISSUE) begin
            bus.mul_a = coef_q[idx_q];
            bus.mul_b = data_q[idx_q];
        end
    end
endmodule

// File: tb/tb_cenn_mac_ctrl.sv
// Bench for cenn_mac_ctrl: multiplier stub, cycle-level reference model,
// per-cycle output compare and directed operations with literal results.
module tb_cenn_mac_ctrl;
    localparam int W = 15;
    localparam int F = 9;
    localparam int T = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    cenn_mac_ctrl_if #(.WIDTH(W), .TAPS(T)) ifc ();
    cenn_mac_ctrl #(.WIDTH(W), .FRAC(F), .TAPS(T), .AW(W + 4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    always #5 clk = ~clk;

    // Shared Q6.9 multiplier with a registered, wrapping product
    logic signed [2*W-1:0] full;
    assign full = $signed(ifc.mul_a) * $signed(ifc.mul_b);
    always_ff @(posedge clk) ifc.mul_p <= full[F +: W];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts cycles since the accepted start edge
    bit           m_act = 1'b0;
    int           m_t = 0;
    logic [W-1:0] m_res = '0, m_pres = '0;
    bit           m_sat = 1'b0, m_psat = 1'b0;
    logic [W-1:0] m_c[T], m_d[T];
    longint       m_s, m_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 1'b0;
            m_res = '0;
            m_sat = 1'b0;
        end else if (ifc.clear) begin
            m_act = 1'b0;
        end else if (m_act) begin
            m_t++;
            if (m_t == T + 1) begin
                m_res = m_pres;
                m_sat = m_psat;
            end
            if (m_t == T + 2) m_act = 1'b0;
        end else if (ifc.start) begin
            m_s = longint'($signed(ifc.bias));
            for (int k = 0; k < T; k++) begin
                m_c[k] = ifc.coef_flat[k*W +: W];
                m_d[k] = ifc.data_flat[k*W +: W];
                m_p = (longint'($signed(m_c[k])) * longint'($signed(m_d[k]))) >>> F;
                m_p = m_p & 32767;
                if (m_p >= 16384) m_p = m_p - 32768;
                m_s = m_s + m_p;
            end
            if (m_s > 16383) begin
                m_pres = 15'h3FFF; m_psat = 1'b1;
            end else if (m_s < -16384) begin
                m_pres = 15'h4000; m_psat = 1'b1;
            end else begin
                m_pres = m_s[W-1:0]; m_psat = 1'b0;
            end
            m_act = 1'b1;
            m_t = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("busy", ifc.busy, (m_act && m_t <= T));
            check("done", ifc.done, (m_act && m_t == T + 1));
            check("mul_a", ifc.mul_a, (m_act && m_t < T) ? m_c[m_t] : '0);
            check("mul_b", ifc.mul_b, (m_act && m_t < T) ? m_d[m_t] : '0);
            check("result", ifc.result, m_res);
            check("sat", ifc.sat, m_sat);
        end
    end

    task automatic set_all(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] b);
        for (int k = 0; k < T; k++) begin
            ifc.coef_flat[k*W +: W] = c;
            ifc.data_flat[k*W +: W] = d;
        end
        ifc.bias = b;
    endtask

    task automatic outputs_zero(input string nm);
        check({nm, "_busy"}, ifc.busy, 0);
        check({nm, "_done"}, ifc.done, 0);
        check({nm, "_result"}, ifc.result, 0);
        check({nm, "_sat"}, ifc.sat, 0);
        check({nm, "_mul_a"}, ifc.mul_a, 0);
        check({nm, "_mul_b"}, ifc.mul_b, 0);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] er, input bit es,
                          input bit scramble, input bit poke);
        int lat = 0;
        int bn = 0;
        bit got = 1'b0;
        @(posedge clk); #1 ifc.start = 1'b1;
        @(posedge clk); #1 ifc.start = 1'b0;
        if (scramble) begin
            for (int k = 0; k < T; k++) begin
                ifc.coef_flat[k*W +: W] = W'($urandom);
                ifc.data_flat[k*W +: W] = W'($urandom);
            end
            ifc.bias = W'($urandom);
        end
        while (!got && lat < 30) begin
            if (ifc.busy) bn++;
            if (ifc.done) got = 1'b1;
            else begin
                if (poke) ifc.start = (lat == 3 || lat == 6);
                @(posedge clk); #1;
                lat++;
            end
        end
        ifc.start = 1'b0;
        check({nm, "_done_seen"}, got, 1);
        check({nm, "_latency"}, lat, 10);
        check({nm, "_busy_cycles"}, bn, 10);
        check({nm, "_result"}, ifc.result, er);
        check({nm, "_sat"}, ifc.sat, es);
    endtask

    initial begin
        int n;
        ifc.start = 1'b0;
        ifc.clear = 1'b0;
        set_all('0, '0, '0);
        #2 outputs_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk_en = 1'b1;

        set_all(15'd512, 15'd512, 15'd0);
        run_op("unity", 15'h1200, 1'b0, 1'b0, 1'b0);
        set_all(15'h7E00, 15'd512, 15'd0);
        run_op("neg", 15'h6E00, 1'b0, 1'b0, 1'b0);
        set_all('0, '0, 15'd256);
        ifc.coef_flat[4*W +: W] = 15'd512;
        ifc.data_flat[4*W +: W] = 15'd1024;
        run_op("bias", 15'd1280, 1'b0, 1'b0, 1'b0);
        set_all(15'd512, 15'h3FFF, 15'h3FFF);
        run_op("sat_pos", 15'h3FFF, 1'b1, 1'b0, 1'b0);
        set_all(15'd512, 15'h4000, 15'h4000);
        run_op("sat_neg", 15'h4000, 1'b1, 1'b0, 1'b0);
        set_all(15'd512, 15'd512, 15'd0);
        run_op("unsat", 15'd4608, 1'b0, 1'b0, 1'b0);
        run_op("poke", 15'd4608, 1'b0, 1'b0, 1'b1);
        set_all(15'd512, 15'd256, 15'd100);
        run_op("latched", 15'd2404, 1'b0, 1'b1, 1'b0);

        // start held high: back-to-back operations
        set_all(15'd512, 15'd512, 15'd0);
        n = 0;
        @(posedge clk); #1 ifc.start = 1'b1;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(posedge clk); #1;
            if (ifc.done) begin
                n++;
                check("cont_result", ifc.result, 4608);
            end
        end
        ifc.start = 1'b0;
        check("cont_ops", n, 3);

        // abort in the fourth ISSUE cycle
        set_all(15'd512, 15'd1024, 15'd0);
        @(posedge clk); #1 ifc.start = 1'b1;
        @(posedge clk); #1 ifc.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 ifc.clear = 1'b1;
        check("abort_busy_before", ifc.busy, 1);
        @(posedge clk); #1 ifc.clear = 1'b0;
        check("abort_idle", ifc.busy, 0);
        check("abort_result_held", ifc.result, 4608);
        set_all(15'd512, 15'd512, 15'd0);
        run_op("after_abort", 15'd4608, 1'b0, 1'b0, 1'b0);

        // clear wins over start in IDLE
        set_all(15'd512, 15'd1024, 15'd0);
        @(posedge clk); #1 begin ifc.start = 1'b1; ifc.clear = 1'b1; end
        @(posedge clk); #1 begin ifc.start = 1'b0; ifc.clear = 1'b0; end
        check("clr_start_busy", ifc.busy, 0);
        repeat (3) @(posedge clk);
        #1 check("clr_start_busy_later", ifc.busy, 0);

        // asynchronous reset during DRAIN
        @(posedge clk); #1 ifc.start = 1'b1;
        @(posedge clk); #1 ifc.start = 1'b0;
        repeat (9) @(posedge clk);
        #3 check("drain_busy", ifc.busy, 1);
        check("drain_mul_a", ifc.mul_a, 0);
        rst_n = 1'b0;
        #1 outputs_zero("mid_reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        set_all(15'd512, 15'd512, 15'd0);
        run_op("post_reset", 15'd4608, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
